// File: rtl/transport_pkg.sv
// rtl/transport_pkg.sv - shared types and constants for the transport controller
package transport_pkg;

  // State encoding is shown on the front-panel display, so values are fixed
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REC        = 3'd1,
    ST_REC_PAUSE  = 3'd2,
    ST_PLAY       = 3'd3,
    ST_PLAY_PAUSE = 3'd4
  } state_e;

  localparam logic signed [3:0] SPEED_MIN = -4'sd7;
  localparam logic signed [3:0] SPEED_MAX = 4'sd7;

  localparam int DEFAULT_ADDR_W = 20;

endpackage

// File: rtl/speed_mapper.sv
// rtl/speed_mapper.sv - maps the signed speed index to clock-generator settings and address stride
module speed_mapper
  import transport_pkg::*;
(
  input  logic signed [3:0] speed_idx,
  input  logic              is_record,
  output logic [2:0]        ratio,
  output logic              is_normal_speed,
  output logic [3:0]        stride
);

  // Negative index slows the sample clock; positive index skips samples; recording is always normal speed
  always_comb begin
    ratio           = 3'd0;
    is_normal_speed = 1'b1;
    stride          = 4'd1;
    if (!is_record) begin
      if (speed_idx < 4'sd0) begin
        ratio           = 3'(-speed_idx);
        is_normal_speed = 1'b0;
      end else if (speed_idx > 4'sd0) begin
        stride = 4'(speed_idx) + 4'd1;
      end
    end
  end

endmodule

// File: rtl/transport_ctrl.sv
// rtl/transport_ctrl.sv - record/play/pause/stop controller with SRAM address sequencing
module transport_ctrl
  import transport_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              keyRecord,
  input  logic              keyPlay,
  input  logic              keyPause,
  input  logic              keyStop,
  input  logic              keyFaster,
  input  logic              keySlower,
  input  logic              keyInterp,
  input  logic              sampleTick,
  output logic [2:0]        ratio,
  output logic              isNormalSpeed,
  output logic              interp,
  output logic              pause,
  output logic              isRecord,
  output logic [ADDR_W-1:0] sramAddr,
  output logic              sramWe,
  output logic [ADDR_W-1:0] lastAddr,
  output logic [2:0]        state
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, last_q, last_d;
  logic signed [3:0]  speed_q, speed_d;
  logic               interp_q, interp_d, we_q, we_d;
  logic               pause_q, pause_d, rec_q, rec_d, nsp_q, nsp_d;
  logic [2:0]         ratio_q, ratio_d;
  logic [3:0]         stride_q, stride_d;
  logic [ADDR_W:0]    next_addr;

  speed_mapper u_speed_mapper (
    .speed_idx       (speed_d),
    .is_record       (rec_d),
    .ratio           (ratio_d),
    .is_normal_speed (nsp_d),
    .stride          (stride_d)
  );

  // Next-state: transport keys by priority, then sample stepping, then completion of a pending write
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
    we_d      = 1'b0;
    speed_d   = speed_q;
    interp_d  = interp_q ^ keyInterp;
    next_addr = {1'b0, addr_q} + (ADDR_W+1)'(stride_q);

    if (keyFaster && !keySlower && speed_q != SPEED_MAX) begin
      speed_d = speed_q + 4'sd1;
    end else if (keySlower && !keyFaster && speed_q != SPEED_MIN) begin
      speed_d = speed_q - 4'sd1;
    end

    if (keyStop) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end else if (keyPause && state_q != ST_IDLE) begin
      case (state_q)
        ST_REC:        state_d = ST_REC_PAUSE;
        ST_REC_PAUSE:  state_d = ST_REC;
        ST_PLAY:       state_d = ST_PLAY_PAUSE;
        ST_PLAY_PAUSE: state_d = ST_PLAY;
        default:       state_d = state_q;
      endcase
    end else if (keyRecord && state_q == ST_IDLE) begin
      state_d = ST_REC;
      addr_d  = '0;
    end else if (keyPlay && state_q == ST_IDLE) begin
      if (last_q != '0) begin
        state_d = ST_PLAY;
        addr_d  = '0;
      end
    end else if (keyPlay && state_q == ST_PLAY_PAUSE) begin
      state_d = ST_PLAY;
    end else if (sampleTick && !we_q) begin
      // A tick landing on the write-strobe cycle is dropped; real sample periods are far longer
      if (state_q == ST_REC) begin
        we_d = 1'b1;
      end else if (state_q == ST_PLAY) begin
        if (next_addr > {1'b0, last_q}) begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end else begin
          addr_d = next_addr[ADDR_W-1:0];
        end
      end
    end

    // The write strobed last cycle is committed: it marks the end of data and advances the address
    if (we_q) begin
      last_d = addr_q;
      if (addr_q == MAX_ADDR) begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end else if (!keyStop) begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    rec_d   = (state_d == ST_REC) || (state_d == ST_REC_PAUSE);
    pause_d = (state_d == ST_REC_PAUSE) || (state_d == ST_PLAY_PAUSE);
  end

  // Register all state and every output
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      last_q   <= '0;
      speed_q  <= 4'sd0;
      interp_q <= 1'b1;
      we_q     <= 1'b0;
      pause_q  <= 1'b0;
      rec_q    <= 1'b0;
      nsp_q    <= 1'b1;
      ratio_q  <= 3'd0;
      stride_q <= 4'd1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      speed_q  <= speed_d;
      interp_q <= interp_d;
      we_q     <= we_d;
      pause_q  <= pause_d;
      rec_q    <= rec_d;
      nsp_q    <= nsp_d;
      ratio_q  <= ratio_d;
      stride_q <= stride_d;
    end
  end

  assign ratio         = ratio_q;
  assign isNormalSpeed = nsp_q;
  assign interp        = interp_q;
  assign pause         = pause_q;
  assign isRecord      = rec_q;
  assign sramAddr      = addr_q;
  assign sramWe        = we_q;
  assign lastAddr      = last_q;
  assign state         = state_q;

endmodule

// File: tb/tb_transport_ctrl.sv
// tb/tb_transport_ctrl.sv - directed self-checking bench for transport_ctrl
module tb_transport_ctrl;

  localparam logic [7:0] K_REC = 8'h01, K_PLAY = 8'h02, K_PAUSE = 8'h04, K_STOP = 8'h08;
  localparam logic [7:0] K_FAST = 8'h10, K_SLOW = 8'h20, K_INTERP = 8'h40, K_TICK = 8'h80;

  logic        clk50 = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  keys  = 8'h00;

  logic [2:0]  ratio, state, ratio3, state3;
  logic        is_normal, interp, pause, is_record, sram_we;
  logic        is_normal3, interp3, pause3, is_record3, sram_we3;
  logic [19:0] sram_addr, last_addr;
  logic [2:0]  sram_addr3, last_addr3;

  int n_vec = 0;
  int n_err = 0;
  int we3_cnt = 0;

  always #10 clk50 = ~clk50;

  transport_ctrl dut (
    .clk50(clk50), .rst_n(rst_n),
    .keyRecord(keys[0]), .keyPlay(keys[1]), .keyPause(keys[2]), .keyStop(keys[3]),
    .keyFaster(keys[4]), .keySlower(keys[5]), .keyInterp(keys[6]), .sampleTick(keys[7]),
    .ratio(ratio), .isNormalSpeed(is_normal), .interp(interp), .pause(pause),
    .isRecord(is_record), .sramAddr(sram_addr), .sramWe(sram_we), .lastAddr(last_addr),
    .state(state)
  );

  transport_ctrl #(.ADDR_W(3)) dut3 (
    .clk50(clk50), .rst_n(rst_n),
    .keyRecord(keys[0]), .keyPlay(keys[1]), .keyPause(keys[2]), .keyStop(keys[3]),
    .keyFaster(keys[4]), .keySlower(keys[5]), .keyInterp(keys[6]), .sampleTick(keys[7]),
    .ratio(ratio3), .isNormalSpeed(is_normal3), .interp(interp3), .pause(pause3),
    .isRecord(is_record3), .sramAddr(sram_addr3), .sramWe(sram_we3), .lastAddr(last_addr3),
    .state(state3)
  );

  always @(posedge clk50) if (sram_we3) we3_cnt = we3_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic press(input logic [7:0] k, input int times = 1);
    for (int i = 0; i < times; i++) begin
      @(negedge clk50); keys = k;
      @(negedge clk50); keys = 8'h00;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk50); @(negedge clk50);
    rst_n = 1'b1;
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
    n_vec++; if (sram_addr !== 20'd0 || last_addr !== 20'd0) begin n_err++; $display("FAIL reset_addr got %0d/%0d exp 0/0", sram_addr, last_addr); end
    n_vec++; if ({interp, sram_we, pause, is_record} !== 4'b1000) begin n_err++; $display("FAIL reset_flags got %b exp 1000", {interp, sram_we, pause, is_record}); end
    n_vec++; if (ratio !== 3'd0 || is_normal !== 1'b1) begin n_err++; $display("FAIL reset_speed got %0d/%b exp 0/1", ratio, is_normal); end
  endtask

  task automatic test_record;
    press(K_REC);
    n_vec++; if (state !== 3'd1 || is_record !== 1'b1) begin n_err++; $display("FAIL rec_enter got %0d/%b exp 1/1", state, is_record); end
    for (int i = 0; i < 5; i++) begin
      press(K_TICK);
      n_vec++; if (sram_we !== 1'b1 || sram_addr !== 20'(i)) begin n_err++; $display("FAIL rec_write%0d got we=%b addr=%0d exp we=1 addr=%0d", i, sram_we, sram_addr, i); end
    end
    @(negedge clk50);
    n_vec++; if (sram_we !== 1'b0 || sram_addr !== 20'd5 || last_addr !== 20'd4) begin n_err++; $display("FAIL rec_after got we=%b addr=%0d last=%0d exp 0/5/4", sram_we, sram_addr, last_addr); end
    press(K_STOP);
    n_vec++; if (state !== 3'd0 || sram_addr !== 20'd0 || last_addr !== 20'd4) begin n_err++; $display("FAIL rec_stop got st=%0d addr=%0d last=%0d exp 0/0/4", state, sram_addr, last_addr); end
  endtask

  task automatic test_play_speed;
    press(K_PLAY);
    n_vec++; if (state !== 3'd3 || sram_addr !== 20'd0) begin n_err++; $display("FAIL play_enter got st=%0d addr=%0d exp 3/0", state, sram_addr); end
    press(K_SLOW, 3);
    n_vec++; if (ratio !== 3'd3 || is_normal !== 1'b0) begin n_err++; $display("FAIL play_slow got %0d/%b exp 3/0", ratio, is_normal); end
    press(K_TICK, 2);
    n_vec++; if (sram_addr !== 20'd2) begin n_err++; $display("FAIL play_step got %0d exp 2", sram_addr); end
    press(K_FAST, 5);
    n_vec++; if (ratio !== 3'd0 || is_normal !== 1'b1) begin n_err++; $display("FAIL play_fast got %0d/%b exp 0/1", ratio, is_normal); end
    press(K_TICK);
    n_vec++; if (state !== 3'd0 || sram_addr !== 20'd0) begin n_err++; $display("FAIL play_end got st=%0d addr=%0d exp 0/0", state, sram_addr); end
  endtask

  task automatic test_saturation;
    press(K_FAST, 10);
    press(K_SLOW, 8);
    n_vec++; if (ratio !== 3'd1 || is_normal !== 1'b0) begin n_err++; $display("FAIL sat_high got %0d/%b exp 1/0", ratio, is_normal); end
    press(K_SLOW, 20);
    n_vec++; if (ratio !== 3'd7) begin n_err++; $display("FAIL sat_low got %0d exp 7", ratio); end
    press(K_FAST);
    n_vec++; if (ratio !== 3'd6) begin n_err++; $display("FAIL sat_low_step got %0d exp 6", ratio); end
    press(K_FAST | K_SLOW);
    n_vec++; if (ratio !== 3'd6) begin n_err++; $display("FAIL both_keys got %0d exp 6", ratio); end
    press(K_FAST, 6);
    n_vec++; if (ratio !== 3'd0 || is_normal !== 1'b1) begin n_err++; $display("FAIL sat_zero got %0d/%b exp 0/1", ratio, is_normal); end
  endtask

  task automatic test_pause;
    press(K_PLAY);
    press(K_TICK);
    press(K_PAUSE);
    n_vec++; if (state !== 3'd4 || pause !== 1'b1) begin n_err++; $display("FAIL pause_enter got %0d/%b exp 4/1", state, pause); end
    press(K_TICK, 3);
    n_vec++; if (sram_addr !== 20'd1 || sram_we !== 1'b0) begin n_err++; $display("FAIL pause_hold got addr=%0d we=%b exp 1/0", sram_addr, sram_we); end
    press(K_PLAY);
    n_vec++; if (state !== 3'd3 || pause !== 1'b0) begin n_err++; $display("FAIL pause_resume got %0d/%b exp 3/0", state, pause); end
    press(K_TICK | K_PAUSE);
    n_vec++; if (state !== 3'd4 || sram_addr !== 20'd1) begin n_err++; $display("FAIL pause_tick got st=%0d addr=%0d exp 4/1", state, sram_addr); end
    press(K_PAUSE);
    press(K_STOP | K_PAUSE | K_TICK);
    n_vec++; if (state !== 3'd0 || sram_addr !== 20'd0) begin n_err++; $display("FAIL stop_prio got st=%0d addr=%0d exp 0/0", state, sram_addr); end
  endtask

  task automatic test_interp_and_rec_speed;
    press(K_INTERP);
    n_vec++; if (interp !== 1'b0) begin n_err++; $display("FAIL interp_toggle got %b exp 0", interp); end
    press(K_INTERP);
    press(K_SLOW, 2);
    press(K_REC);
    n_vec++; if (ratio !== 3'd0 || is_normal !== 1'b1 || interp !== 1'b1) begin n_err++; $display("FAIL rec_forced got %0d/%b/%b exp 0/1/1", ratio, is_normal, interp); end
    press(K_PAUSE);
    n_vec++; if (state !== 3'd2 || pause !== 1'b1 || is_record !== 1'b1) begin n_err++; $display("FAIL rec_pause got %0d/%b/%b exp 2/1/1", state, pause, is_record); end
    press(K_STOP);
    n_vec++; if (ratio !== 3'd2 || is_normal !== 1'b0) begin n_err++; $display("FAIL speed_kept got %0d/%b exp 2/0", ratio, is_normal); end
    press(K_FAST, 2);
  endtask

  task automatic test_small_addr;
    int c0;
    press(K_STOP);
    c0 = we3_cnt;
    press(K_REC);
    press(K_TICK, 9);
    @(negedge clk50); @(negedge clk50);
    n_vec++; if (we3_cnt - c0 != 8) begin n_err++; $display("FAIL small_strobes got %0d exp 8", we3_cnt - c0); end
    n_vec++; if (last_addr3 !== 3'd7 || state3 !== 3'd0 || sram_addr3 !== 3'd0) begin n_err++; $display("FAIL small_end got last=%0d st=%0d addr=%0d exp 7/0/0", last_addr3, state3, sram_addr3); end
  endtask

  task automatic test_reset_mid_rec;
    press(K_STOP);
    press(K_REC);
    press(K_TICK, 3);
    @(negedge clk50);
    n_vec++; if (sram_addr !== 20'd3 || state !== 3'd1) begin n_err++; $display("FAIL mid_addr got addr=%0d st=%0d exp 3/1", sram_addr, state); end
    rst_n = 1'b0;
    @(negedge clk50);
    rst_n = 1'b1;
    n_vec++; if (state !== 3'd0 || sram_addr !== 20'd0 || last_addr !== 20'd0 || is_record !== 1'b0) begin n_err++; $display("FAIL mid_reset got st=%0d addr=%0d last=%0d rec=%b exp 0/0/0/0", state, sram_addr, last_addr, is_record); end
    press(K_PLAY);
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL play_empty got %0d exp 0", state); end
  endtask

  initial begin
    test_reset;
    test_record;
    test_play_speed;
    test_saturation;
    test_pause;
    test_interp_and_rec_speed;
    test_small_addr;
    test_reset_mid_rec;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
